// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, threshold flags, ack and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
`default_nettype none

module sync_fifo_flags #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 512,
   parameter int ADDR       = 9,
   parameter int AF_TH      = FIFO_DEPTH - 2,
   parameter int AE_TH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FIFO_WIDTH-1:0] din,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [FIFO_WIDTH-1:0] dout,
   output logic                  valid,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [ADDR:0]         count
);

   localparam logic [ADDR:0] c_one   = (ADDR+1)'(1);
   localparam logic [ADDR:0] c_depth = (ADDR+1)'(FIFO_DEPTH);
   localparam logic [ADDR:0] c_af    = (ADDR+1)'(AF_TH);
   localparam logic [ADDR:0] c_ae    = (ADDR+1)'(AE_TH);

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [ADDR:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR:0] count_q, count_d;
   logic          wr_ack_q, wr_ack_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          wr_accept, rd_accept;

   assign full        = (count_q == c_depth);
   assign empty       = (count_q == '0);
   assign almostfull  = (count_q >= c_af);
   assign almostempty = (count_q <= c_ae);
   assign count       = count_q;
   assign wr_ack      = wr_ack_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

   // Full/empty gating alone resolves the simultaneous-request corner cases.
   always_comb begin
      wr_accept   = wr_en && !full;
      rd_accept   = rd_en && !empty;
      wr_ptr_d    = wr_accept ? wr_ptr_q + c_one : wr_ptr_q;
      rd_ptr_d    = rd_accept ? rd_ptr_q + c_one : rd_ptr_q;
      wr_ack_d    = wr_accept;
      overflow_d  = wr_en && full;
      underflow_d = rd_en && empty;
      count_d     = count_q;
      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + c_one;
         2'b01:   count_d = count_q - c_one;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst && wr_accept) begin
         mem[wr_ptr_q[ADDR-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wr_ack_q    <= wr_ack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef FIFO_FWFT_EN
   assign dout  = mem[rd_ptr_q[ADDR-1:0]];
   assign valid = !empty;
`else
   logic [FIFO_WIDTH-1:0] dout_q, dout_d;
   logic                  valid_q, valid_d;

   always_comb begin
      dout_d  = rd_accept ? mem[rd_ptr_q[ADDR-1:0]] : dout_q;
      valid_d = rd_accept;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign dout  = dout_q;
   assign valid = valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed self-checking bench for sync_fifo_flags (depth 8).
`default_nettype none

module tb_sync_fifo_flags;

   logic        clk;
   logic        rst;
   logic [15:0] din;
   logic        wr_en;
   logic        rd_en;
   logic [15:0] dout;
   logic        valid;
   logic        wr_ack;
   logic        overflow;
   logic        underflow;
   logic        full;
   logic        empty;
   logic        almostfull;
   logic        almostempty;
   logic [3:0]  count;

   int n_checks = 0;
   int n_errors = 0;
   int n_cyc    = 0;

   logic [15:0] mq[$];
   logic [15:0] last_dout;

   sync_fifo_flags #(
      .FIFO_WIDTH(16),
      .FIFO_DEPTH(8),
      .ADDR      (3),
      .AF_TH     (6),
      .AE_TH     (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .dout       (dout),
      .valid      (valid),
      .wr_ack     (wr_ack),
      .overflow   (overflow),
      .underflow  (underflow),
      .full       (full),
      .empty      (empty),
      .almostfull (almostfull),
      .almostempty(almostempty),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, n_cyc, got, exp);
      end
   endtask

   task automatic check_flags();
      int sz;
      sz = mq.size();
      check("count",       32'(count),       32'(sz));
      check("empty",       32'(empty),       32'(sz == 0));
      check("full",        32'(full),        32'(sz == 8));
      check("almostfull",  32'(almostfull),  32'(sz >= 6));
      check("almostempty", 32'(almostempty), 32'(sz <= 2));
   endtask

   // One clock with the given requests; expectations come from the queue model.
   task automatic cyc(input logic w, input logic r, input logic [15:0] d);
      logic e_wack, e_ovf, e_unf, e_rd;
      e_wack = w && (mq.size() < 8);
      e_ovf  = w && (mq.size() == 8);
      e_rd   = r && (mq.size() != 0);
      e_unf  = r && (mq.size() == 0);
      if (e_rd) last_dout = mq.pop_front();
      if (e_wack) mq.push_back(d);
      wr_en = w;
      rd_en = r;
      din   = d;
      @(posedge clk);
      #1;
      n_cyc++;
      check("wr_ack",    32'(wr_ack),    32'(e_wack));
      check("overflow",  32'(overflow),  32'(e_ovf));
      check("underflow", 32'(underflow), 32'(e_unf));
`ifdef FIFO_FWFT_EN
      check("valid", 32'(valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("dout", 32'(dout), 32'(mq[0]));
`else
      check("valid", 32'(valid), 32'(e_rd));
      check("dout",  32'(dout),  32'(last_dout));
`endif
      check_flags();
   endtask

   // Reset edge with the given requests pending; they must be dropped.
   task automatic do_reset(input logic w, input logic r);
      rst   = 1'b0;
      wr_en = w;
      rd_en = r;
      din   = 16'hDEAD;
      @(posedge clk);
      #1;
      n_cyc++;
      mq.delete();
      last_dout = '0;
      check("rst_wr_ack",    32'(wr_ack),    32'(0));
      check("rst_overflow",  32'(overflow),  32'(0));
      check("rst_underflow", 32'(underflow), 32'(0));
      check("rst_valid",     32'(valid),     32'(0));
`ifndef FIFO_FWFT_EN
      check("rst_dout", 32'(dout), 32'(0));
`endif
      check_flags();
      rst   = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      din       = '0;
      last_dout = '0;
      @(posedge clk);
      #1;
      do_reset(1'b0, 1'b0);

      for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 16'(i));
      cyc(1'b1, 1'b0, 16'hBEEF);
      cyc(1'b0, 1'b0, 16'h0000);

      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 16'h0000);
      cyc(1'b0, 1'b1, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000);

      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0010 + 16'(i));
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 16'h0020 + 16'(i));

      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0040 + 16'(i));
      cyc(1'b1, 1'b1, 16'h0077);
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 16'h0000);
      cyc(1'b1, 1'b1, 16'h0055);

      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0060 + 16'(i));
      do_reset(1'b1, 1'b1);

      cyc(1'b1, 1'b0, 16'h00A5);
      cyc(1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b1, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
